// File: rtl/dsm_pkg.sv
// Shared types and helpers for the multichannel duty/period measurement array.
// Channel FSM encoding plus width and packing helpers used by the top and interface.
package dsm_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RISE = 3'd1,
      HIGH      = 3'd2,
      LOW       = 3'd3,
      DONE      = 3'd4
   } dsm_state_t;

   // Width of the avg_log2 control field; never zero even when averaging is disabled.
   function automatic int avg_width(input int max_log2);
      return (max_log2 > 0) ? $clog2(max_log2 + 1) : 1;
   endfunction

   // LSB position of channel ch inside a flat bus of per-channel fields of width w.
   function automatic int pack_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/dsm_multichannel_avg_if.sv
// Control/result bundle between the pin mux, the measurement array and the readback layer.
interface dsm_multichannel_avg_if
   import dsm_pkg::*;
#(
   parameter int NUM_CHANNELS = 8,
   parameter int CNT_W        = 16,
   parameter int MAX_AVG_LOG2 = 3
);
   localparam int AVG_W = avg_width(MAX_AVG_LOG2);

   logic [NUM_CHANNELS-1:0]         measure_start;
   logic [NUM_CHANNELS-1:0]         measure_pin;
   logic [AVG_W-1:0]                avg_log2;
   logic [NUM_CHANNELS*CNT_W-1:0]   high_time;
   logic [NUM_CHANNELS*CNT_W-1:0]   low_time;
   logic [NUM_CHANNELS*(CNT_W+1)-1:0] period;
   logic [NUM_CHANNELS-1:0]         measure_busy;
   logic [NUM_CHANNELS-1:0]         measure_done;
   logic [NUM_CHANNELS-1:0]         measure_tmo;

   modport master (
      output measure_start, measure_pin, avg_log2,
      input  high_time, low_time, period, measure_busy, measure_done, measure_tmo
   );

   modport slave (
      input  measure_start, measure_pin, avg_log2,
      output high_time, low_time, period, measure_busy, measure_done, measure_tmo
   );

endinterface

// File: rtl/dsm_avg_channel.sv
// One measurement channel: pin synchroniser, edge detect, phase FSM, accumulators
// and the averaged result registers.
module dsm_avg_channel
   import dsm_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int MAX_AVG_LOG2   = 3,
   parameter int TIMEOUT_CYCLES = 65000,
   parameter int AVG_W          = avg_width(MAX_AVG_LOG2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pin,
   input  logic [AVG_W-1:0] avg_log2,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic [CNT_W:0]   period,
   output logic             busy,
   output logic             done,
   output logic             tmo
);
   localparam int ACC_W = CNT_W + MAX_AVG_LOG2;
   localparam int PER_W = MAX_AVG_LOG2 + 1;

   logic             sync1_reg, sync2_reg, hist_reg;
   dsm_state_t       state_reg, state_next;
   logic [CNT_W-1:0] phase_reg, phase_next;
   logic [ACC_W-1:0] acc_hi_reg, acc_hi_next, acc_lo_reg, acc_lo_next;
   logic [PER_W-1:0] periods_reg, periods_next;
   logic [AVG_W-1:0] k_reg, k_next;
   logic [CNT_W-1:0] high_reg, high_next, low_reg, low_next;
   logic [CNT_W:0]   period_reg, period_next;
   logic             done_reg, done_next, tmo_reg, tmo_next;

   logic             rise, fall, timed_out, abort;
   logic [PER_W-1:0] period_mask;
   logic [CNT_W-1:0] hi_shift, lo_shift;

   assign rise        = sync2_reg & ~hist_reg;
   assign fall        = ~sync2_reg & hist_reg;
   assign timed_out   = (phase_reg == CNT_W'(TIMEOUT_CYCLES));
   assign period_mask = (PER_W'(1) << k_reg) - PER_W'(1);
   assign hi_shift    = CNT_W'(acc_hi_reg >> k_reg);
   assign lo_shift    = CNT_W'(acc_lo_reg >> k_reg);

   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      acc_hi_next  = acc_hi_reg;
      acc_lo_next  = acc_lo_reg;
      periods_next = periods_reg;
      k_next       = k_reg;
      high_next    = high_reg;
      low_next     = low_reg;
      period_next  = period_reg;
      done_next    = 1'b0;
      tmo_next     = tmo_reg;
      abort        = 1'b0;
      // A start always wins, including in DONE, so an interrupted run never reports.
      if (start) begin
         state_next   = WAIT_RISE;
         phase_next   = '0;
         acc_hi_next  = '0;
         acc_lo_next  = '0;
         periods_next = '0;
         k_next       = (int'(avg_log2) > MAX_AVG_LOG2) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
         tmo_next     = 1'b0;
      end else begin
         case (state_reg)
            IDLE: ;
            WAIT_RISE: begin
               if (rise) begin
                  state_next = HIGH;
                  phase_next = CNT_W'(1);
               end else if (timed_out) abort = 1'b1;
               else phase_next = phase_reg + CNT_W'(1);
            end
            HIGH: begin
               if (fall) begin
                  state_next  = LOW;
                  acc_hi_next = acc_hi_reg + ACC_W'(phase_reg);
                  phase_next  = CNT_W'(1);
               end else if (timed_out) abort = 1'b1;
               else phase_next = phase_reg + CNT_W'(1);
            end
            LOW: begin
               if (rise) begin
                  acc_lo_next = acc_lo_reg + ACC_W'(phase_reg);
                  if (periods_reg == period_mask) begin
                     state_next = DONE;
                  end else begin
                     state_next   = HIGH;
                     periods_next = periods_reg + PER_W'(1);
                     phase_next   = CNT_W'(1);
                  end
               end else if (timed_out) abort = 1'b1;
               else phase_next = phase_reg + CNT_W'(1);
            end
            DONE: begin
               high_next   = hi_shift;
               low_next    = lo_shift;
               period_next = {1'b0, hi_shift} + {1'b0, lo_shift};
               done_next   = 1'b1;
               state_next  = IDLE;
            end
            default: state_next = IDLE;
         endcase
         if (abort) begin
            state_next  = IDLE;
            high_next   = '0;
            low_next    = '0;
            period_next = '0;
            done_next   = 1'b1;
            tmo_next    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         hist_reg    <= 1'b0;
         state_reg   <= IDLE;
         phase_reg   <= '0;
         acc_hi_reg  <= '0;
         acc_lo_reg  <= '0;
         periods_reg <= '0;
         k_reg       <= '0;
         high_reg    <= '0;
         low_reg     <= '0;
         period_reg  <= '0;
         done_reg    <= 1'b0;
         tmo_reg     <= 1'b0;
      end else begin
         sync1_reg   <= pin;
         sync2_reg   <= sync1_reg;
         hist_reg    <= sync2_reg;
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         acc_hi_reg  <= acc_hi_next;
         acc_lo_reg  <= acc_lo_next;
         periods_reg <= periods_next;
         k_reg       <= k_next;
         high_reg    <= high_next;
         low_reg     <= low_next;
         period_reg  <= period_next;
         done_reg    <= done_next;
         tmo_reg     <= tmo_next;
      end
   end

   assign high_time = high_reg;
   assign low_time  = low_reg;
   assign period    = period_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign tmo       = tmo_reg;

endmodule

// File: rtl/dsm_multichannel_avg.sv
// N-channel high/low/period measurement array: independent channel instances
// whose results are packed onto flat per-channel buses.
module dsm_multichannel_avg
   import dsm_pkg::*;
#(
   parameter int NUM_CHANNELS   = 8,
   parameter int CNT_W          = 16,
   parameter int MAX_AVG_LOG2   = 3,
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dsm_multichannel_avg_if.slave bus
);
   localparam int AVG_W = avg_width(MAX_AVG_LOG2);

   logic [CNT_W-1:0]        high_arr   [NUM_CHANNELS];
   logic [CNT_W-1:0]        low_arr    [NUM_CHANNELS];
   logic [CNT_W:0]          period_arr [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] busy_v, done_v, tmo_v;

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      dsm_avg_channel #(
         .CNT_W          (CNT_W),
         .MAX_AVG_LOG2   (MAX_AVG_LOG2),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .AVG_W          (AVG_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (bus.measure_start[gi]),
         .pin       (bus.measure_pin[gi]),
         .avg_log2  (bus.avg_log2),
         .high_time (high_arr[gi]),
         .low_time  (low_arr[gi]),
         .period    (period_arr[gi]),
         .busy      (busy_v[gi]),
         .done      (done_v[gi]),
         .tmo       (tmo_v[gi])
      );
   end

   always_comb begin
      bus.high_time = '0;
      bus.low_time  = '0;
      bus.period    = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         bus.high_time[pack_lsb(c, CNT_W) +: CNT_W]   = high_arr[c];
         bus.low_time[pack_lsb(c, CNT_W) +: CNT_W]    = low_arr[c];
         bus.period[pack_lsb(c, CNT_W + 1) +: CNT_W + 1] = period_arr[c];
      end
   end

   assign bus.measure_busy = busy_v;
   assign bus.measure_done = done_v;
   assign bus.measure_tmo  = tmo_v;

endmodule

// File: tb/tb_dsm_multichannel_avg.sv
// Directed bench for dsm_multichannel_avg: scheduled pin waveforms per channel,
// done pulses captured each cycle, expectations hand-computed from the waveforms.
module tb_dsm_multichannel_avg;
   localparam int NCH  = 8;
   localparam int CW   = 16;
   localparam int MAXL = 3;
   localparam int TMO  = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dsm_multichannel_avg_if #(.NUM_CHANNELS(NCH), .CNT_W(CW), .MAX_AVG_LOG2(MAXL)) bus ();

   dsm_multichannel_avg #(
      .NUM_CHANNELS(NCH), .CNT_W(CW), .MAX_AVG_LOG2(MAXL), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int seg_lvl [NCH][16];
   int seg_len [NCH][16];
   int seg_n [NCH];
   int seg_i [NCH];
   int seg_c [NCH];
   int done_cnt [NCH];
   logic [31:0] cap_hi [NCH];
   logic [31:0] cap_lo [NCH];
   logic [31:0] cap_per [NCH];
   logic [31:0] cap_tmo [NCH];
   logic [NCH-1:0] pin_v = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_sched(input int ch);
      seg_n[ch] = 0;
      seg_i[ch] = 0;
      seg_c[ch] = 0;
   endtask

   task automatic add_seg(input int ch, input int lvl, input int len);
      seg_lvl[ch][seg_n[ch]] = lvl;
      seg_len[ch][seg_n[ch]] = len;
      seg_n[ch]++;
   endtask

   // One clock: capture done pulses, then advance every channel's pin schedule.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         if (bus.measure_done[ch]) begin
            done_cnt[ch]++;
            cap_hi[ch]  = 32'(bus.high_time[ch*CW +: CW]);
            cap_lo[ch]  = 32'(bus.low_time[ch*CW +: CW]);
            cap_per[ch] = 32'(bus.period[ch*(CW+1) +: CW+1]);
            cap_tmo[ch] = 32'(bus.measure_tmo[ch]);
            $display("[TB] t=%0t ch%0d done high=%0d low=%0d period=%0d tmo=%0d",
                     $time, ch, cap_hi[ch], cap_lo[ch], cap_per[ch], cap_tmo[ch]);
         end
         if (seg_i[ch] < seg_n[ch]) begin
            pin_v[ch] = (seg_lvl[ch][seg_i[ch]] != 0);
            seg_c[ch]++;
            if (seg_c[ch] == seg_len[ch][seg_i[ch]]) begin
               seg_i[ch]++;
               seg_c[ch] = 0;
            end
         end else begin
            pin_v[ch] = 1'b0;
         end
      end
      bus.measure_pin = pin_v;
   endtask

   task automatic pulse_start(input logic [NCH-1:0] mask, input int k);
      bus.measure_start = mask;
      bus.avg_log2      = 2'(k);
      tick();
      bus.measure_start = '0;
   endtask

   task automatic wait_done(input int ch, input int budget, input string tag, output int n);
      int base;
      base = done_cnt[ch];
      n = 0;
      while (done_cnt[ch] == base && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(done_cnt[ch] - base), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_high"},   32'(|bus.high_time),    32'd0);
      check({tag, "_low"},    32'(|bus.low_time),     32'd0);
      check({tag, "_period"}, 32'(|bus.period),       32'd0);
      check({tag, "_busy"},   32'(|bus.measure_busy), 32'd0);
      check({tag, "_done"},   32'(|bus.measure_done), 32'd0);
      check({tag, "_tmo"},    32'(|bus.measure_tmo),  32'd0);
   endtask

   initial begin
      int n, d7, base1, base2, base7, total_base, total_now, all_done;
      int base6 [NCH];

      for (int c = 0; c < NCH; c++) begin
         clear_sched(c);
         done_cnt[c] = 0;
         cap_hi[c] = '0; cap_lo[c] = '0; cap_per[c] = '0; cap_tmo[c] = '0;
      end
      bus.measure_start = '0;
      bus.measure_pin   = '0;
      bus.avg_log2      = '0;

      // Power-on reset.
      rst_n = 1'b0;
      repeat (4) tick();
      check_all_zero("por");
      rst_n = 1'b1;
      tick();

      // ch0 30/70 and ch1 12/8, single period each.
      add_seg(0, 0, 5); add_seg(0, 1, 30); add_seg(0, 0, 70); add_seg(0, 1, 30);
      add_seg(1, 0, 5); add_seg(1, 1, 12); add_seg(1, 0, 8);  add_seg(1, 1, 10);
      base1 = done_cnt[1];
      pulse_start(8'h03, 0);
      check("t2_busy_ch0", 32'(bus.measure_busy[0]), 32'd1);
      wait_done(0, 400, "t2_done_ch0", n);
      check("t2_high_ch0", cap_hi[0], 32'd30);
      check("t2_low_ch0", cap_lo[0], 32'd70);
      check("t2_period_ch0", cap_per[0], 32'd100);
      check("t2_tmo_ch0", cap_tmo[0], 32'd0);
      check("t2_done_ch1", 32'(done_cnt[1] - base1), 32'd1);
      check("t2_high_ch1", cap_hi[1], 32'd12);
      check("t2_low_ch1", cap_lo[1], 32'd8);
      check("t2_period_ch1", cap_per[1], 32'd20);

      // ch3 averaging over 4 periods: highs 10,11,10,11 -> 42>>2 = 10.
      clear_sched(3);
      add_seg(3, 0, 5);
      add_seg(3, 1, 10); add_seg(3, 0, 20); add_seg(3, 1, 11); add_seg(3, 0, 20);
      add_seg(3, 1, 10); add_seg(3, 0, 20); add_seg(3, 1, 11); add_seg(3, 0, 20);
      add_seg(3, 1, 5);
      pulse_start(8'h08, 2);
      wait_done(3, 600, "t3_done", n);
      check("t3_high", cap_hi[3], 32'd10);
      check("t3_low", cap_lo[3], 32'd20);
      check("t3_period", cap_per[3], 32'd30);
      check("t3_tmo", cap_tmo[3], 32'd0);

      // ch1 timeout with the pin stuck low.
      clear_sched(1);
      pulse_start(8'h02, 0);
      wait_done(1, 400, "t4_done", n);
      check("t4_latency_near_200", 32'(n >= TMO - 1 && n <= TMO + 2), 32'd1);
      check("t4_tmo", cap_tmo[1], 32'd1);
      check("t4_high_zero", cap_hi[1], 32'd0);
      check("t4_low_zero", cap_lo[1], 32'd0);
      check("t4_period_zero", cap_per[1], 32'd0);
      pulse_start(8'h02, 0);
      check("t4_tmo_cleared", 32'(bus.measure_tmo[1]), 32'd0);

      // ch2 restarted mid-HIGH; only the second run (40/25) may report.
      clear_sched(2);
      add_seg(2, 0, 5); add_seg(2, 1, 40); add_seg(2, 0, 30);
      add_seg(2, 1, 40); add_seg(2, 0, 25); add_seg(2, 1, 5);
      base2 = done_cnt[2];
      pulse_start(8'h04, 0);
      repeat (19) tick();
      pulse_start(8'h04, 0);
      wait_done(2, 300, "t5_done", n);
      check("t5_high", cap_hi[2], 32'd40);
      check("t5_low", cap_lo[2], 32'd25);
      check("t5_period", cap_per[2], 32'd65);
      repeat (30) tick();
      check("t5_single_done", 32'(done_cnt[2] - base2), 32'd1);

      // All channels together: high 5+3c, low 30-2c.
      for (int c = 0; c < NCH; c++) begin
         clear_sched(c);
         add_seg(c, 0, 4); add_seg(c, 1, 5 + 3*c); add_seg(c, 0, 30 - 2*c); add_seg(c, 1, 5);
         base6[c] = done_cnt[c];
      end
      pulse_start(8'hFF, 0);
      d7 = 0;
      n = 0;
      all_done = 0;
      while (n < 300 && all_done == 0) begin
         tick();
         n++;
         if (d7 == 0 && done_cnt[7] != base6[7]) d7 = n;
         all_done = 1;
         for (int c = 0; c < NCH; c++)
            if (done_cnt[c] == base6[c]) all_done = 0;
      end
      check("t6_all_done", 32'(all_done), 32'd1);
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("t6_done_ch%0d", c), 32'(done_cnt[c] - base6[c]), 32'd1);
         check($sformatf("t6_high_ch%0d", c), cap_hi[c], 32'(5 + 3*c));
         check($sformatf("t6_low_ch%0d", c), cap_lo[c], 32'(30 - 2*c));
         check($sformatf("t6_period_ch%0d", c), cap_per[c], 32'(35 + c));
      end

      // ch7 rerun with a different duty but the same total length, restarted in its DONE cycle.
      clear_sched(7);
      add_seg(7, 0, 4); add_seg(7, 1, 20); add_seg(7, 0, 22); add_seg(7, 1, 5);
      base7 = done_cnt[7];
      pulse_start(8'h80, 0);
      repeat (d7 - 1) tick();
      pulse_start(8'h80, 0);
      repeat (100) tick();
      check("t6_ch7_done_suppressed", 32'(done_cnt[7] - base7), 32'd0);
      check("t6_ch7_high_held", 32'(bus.high_time[7*CW +: CW]), 32'd26);
      check("t6_ch7_low_held", 32'(bus.low_time[7*CW +: CW]), 32'd16);
      check("t6_ch7_period_held", 32'(bus.period[7*(CW+1) +: CW+1]), 32'd42);
      check("t6_ch7_busy_restart", 32'(bus.measure_busy[7]), 32'd1);

      // Reset in the middle of measurements on ch0 and ch7.
      clear_sched(0);
      add_seg(0, 0, 3); add_seg(0, 1, 50);
      pulse_start(8'h01, 0);
      repeat (20) tick();
      rst_n = 1'b0;
      repeat (4) tick();
      check_all_zero("t1_reset");
      rst_n = 1'b1;
      total_base = 0;
      for (int c = 0; c < NCH; c++) total_base += done_cnt[c];
      repeat (TMO + 50) tick();
      total_now = 0;
      for (int c = 0; c < NCH; c++) total_now += done_cnt[c];
      check("t1_no_done_after_reset", 32'(total_now - total_base), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
